clocking_drive_sample: RTL and testbench

- Synthesisable multi-channel model of a synchronous testbench port: a clocking-block equivalent in RTL.
- Each channel drives an output bus from a queued stream of (value, hold) commands.
- Each channel samples an input bus through a fixed input-skew pipeline and flags sampled changes.
- Sits between a testbench sequencer and a DUT interface, generalising a single-wire clocking block to N channels, arbitrary width and queued drives.

---
 rtl/clocking_drive_sample.sv | 186 ++++++++++++++++++
 tb/tb_clocking_drive_sample.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clocking_drive_sample.sv
`default_nettype none
// ============================================================================
// Module      : clocking_drive_sample
// Description : Multi-channel RTL clocking block. Each channel replays a
//               queue of (value, hold) drive commands onto its output bus
//               and samples its input bus through a fixed skew pipeline,
//               flagging sampled changes with a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module clocking_drive_sample #(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 2,
    parameter int               DEPTH     = 4,
    parameter int               HOLD_W    = 4,
    parameter int               SKEW      = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [CW-1:0]               cmd_chan,
    input  logic [WIDTH-1:0]            cmd_data,
    input  logic [HOLD_W-1:0]           cmd_hold,
    output logic [CHANNELS*WIDTH-1:0]   drv_out,
    output logic [CHANNELS-1:0]         drv_busy,
    input  logic [CHANNELS*WIDTH-1:0]   smp_in,
    output logic [CHANNELS*WIDTH-1:0]   smp_out,
    output logic [CHANNELS-1:0]         smp_change
);

    localparam int              c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(DEPTH);
    localparam logic [0:0]      c_ST_IDLE = 1'b0;
    localparam logic [0:0]      c_ST_HOLD = 1'b1;

    logic [CHANNELS-1:0] w_full;
    logic                w_sel_full;
    logic                w_chan_ok;

    // Full flag of the addressed channel; an out-of-range channel reads as full
    always_comb begin
        w_sel_full = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (32'(cmd_chan) == c) begin
                w_sel_full = w_full[c];
            end
        end
    end

    assign w_chan_ok = (32'(cmd_chan) < CHANNELS);
    // Full is the pre-pop occupancy, so a full FIFO never accepts even while popping
    assign cmd_ready = !rst && w_chan_ok && !w_sel_full;

    // ------------------------------------------------------------------------
    // Drive side: one command FIFO and one IDLE/HOLD sequencer per channel
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [WIDTH-1:0]  r_dmem [DEPTH];
        logic [HOLD_W-1:0] r_hmem [DEPTH];
        logic [c_AW-1:0]   r_wp;
        logic [c_AW-1:0]   r_rp;
        logic [c_AW:0]     r_cnt;
        logic [0:0]        r_state;
        logic [HOLD_W-1:0] r_hcnt;
        logic [WIDTH-1:0]  r_drv;
        logic              w_push;
        logic              w_pop;
        logic              w_empty;

        assign w_push    = cmd_valid && cmd_ready && (32'(cmd_chan) == c);
        assign w_empty   = (r_cnt == '0);
        assign w_full[c] = (r_cnt == c_FULL);
        // A new command is taken when idle, or when the current hold has expired
        assign w_pop     = !w_empty && ((r_state == c_ST_IDLE) || (r_hcnt == '0));

        // Command storage; contents are don't-care while the count says empty
        always_ff @(posedge clk) begin
            if (w_push) begin
                r_dmem[r_wp] <= cmd_data;
                r_hmem[r_wp] <= cmd_hold;
            end
        end

        // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged
        always_ff @(posedge clk) begin
            if (rst) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_wp <= r_wp + c_AW'(1);
                end
                if (w_pop) begin
                    r_rp <= r_rp + c_AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_cnt <= r_cnt + (c_AW + 1)'(1);
                end else if (!w_push && w_pop) begin
                    r_cnt <= r_cnt - (c_AW + 1)'(1);
                end
            end
        end

        // Drive sequencer: each value is held for hold+1 cycles, back-to-back with no gap
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state <= c_ST_IDLE;
                r_hcnt  <= '0;
                r_drv   <= RESET_VAL;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_pop) begin
                            r_drv   <= r_dmem[r_rp];
                            r_hcnt  <= r_hmem[r_rp];
                            r_state <= c_ST_HOLD;
                        end
                    end
                    c_ST_HOLD: begin
                        if (r_hcnt != '0) begin
                            r_hcnt <= r_hcnt - HOLD_W'(1);
                        end else if (w_pop) begin
                            r_drv  <= r_dmem[r_rp];
                            r_hcnt <= r_hmem[r_rp];
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                    end
                endcase
            end
        end

        assign drv_out[c*WIDTH +: WIDTH] = r_drv;
        assign drv_busy[c]               = (r_state == c_ST_HOLD);
    end

    // ------------------------------------------------------------------------
    // Sample side: SKEW-stage delay line and change detector
    // ------------------------------------------------------------------------
    logic [CHANNELS*WIDTH-1:0] r_pipe [SKEW];
    logic [CHANNELS*WIDTH-1:0] w_smp_next;
    logic [CHANNELS-1:0]       r_chg;

    // Input skew pipeline; the last stage is the visible sample
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SKEW; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= smp_in;
            for (int i = 1; i < SKEW; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // Value the visible sample will take at the next edge
    if (SKEW == 1) begin : g_skew_one
        assign w_smp_next = smp_in;
    end else begin : g_skew_multi
        assign w_smp_next = r_pipe[SKEW-2];
    end

    // Change pulse is registered alongside the sample it describes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chg <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_chg[c] <= (w_smp_next[c*WIDTH +: WIDTH] != r_pipe[SKEW-1][c*WIDTH +: WIDTH]);
            end
        end
    end

    assign smp_out    = r_pipe[SKEW-1];
    assign smp_change = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_clocking_drive_sample.sv
`default_nettype none
// ============================================================================
// Module      : tb_clocking_drive_sample
// Description : Self-checking bench for clocking_drive_sample. Directed
//               scenarios followed by random traffic, all compared against
//               a queue-based behavioural model of drive and sample behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clocking_drive_sample;

    localparam int          WIDTH  = 8;
    localparam int          CH     = 3;
    localparam int          DEPTH  = 4;
    localparam int          HOLD_W = 4;
    localparam int          SKEW   = 1;
    localparam int          CW     = 2;
    localparam logic [7:0]  RV     = 8'h5A;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CW-1:0]        cmd_chan;
    logic [WIDTH-1:0]     cmd_data;
    logic [HOLD_W-1:0]    cmd_hold;
    logic [CH*WIDTH-1:0]  drv_out;
    logic [CH-1:0]        drv_busy;
    logic [CH*WIDTH-1:0]  smp_in;
    logic [CH*WIDTH-1:0]  smp_out;
    logic [CH-1:0]        smp_change;

    clocking_drive_sample #(
        .WIDTH     (WIDTH),
        .CHANNELS  (CH),
        .DEPTH     (DEPTH),
        .HOLD_W    (HOLD_W),
        .SKEW      (SKEW),
        .RESET_VAL (RV)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_chan   (cmd_chan),
        .cmd_data   (cmd_data),
        .cmd_hold   (cmd_hold),
        .drv_out    (drv_out),
        .drv_busy   (drv_busy),
        .smp_in     (smp_in),
        .smp_out    (smp_out),
        .smp_change (smp_change)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: per-channel command queue, current value and the number
    // of cycles the current value still has to stay on the bus.
    logic [11:0]         mq   [CH][$];
    logic [7:0]          cur  [CH];
    int                  left [CH];
    logic [CH*WIDTH-1:0] hist [$];
    logic [CH*WIDTH-1:0] e_smp;
    logic [CH-1:0]       e_chg;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            mq[c].delete();
            cur[c]  = RV;
            left[c] = 0;
        end
        hist.delete();
        e_smp = '0;
        e_chg = '0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model at the rising edge
    task automatic run_cycle();
        logic              exp_rdy;
        logic              acc;
        logic [CH*8-1:0]   e_drv;
        logic [CH-1:0]     e_busy;
        logic [CH*8-1:0]   nout;
        logic [11:0]       ent;
        @(negedge clk);
        exp_rdy = 1'b0;
        if (!rst && int'(cmd_chan) < CH) begin
            exp_rdy = (mq[cmd_chan].size() < DEPTH);
        end
        for (int c = 0; c < CH; c++) begin
            e_drv[c*8 +: 8] = cur[c];
            e_busy[c]       = (left[c] > 0);
        end
        check_eq("cmd_ready", cmd_ready, exp_rdy);
        check_eq("drv_out", drv_out, e_drv);
        check_eq("drv_busy", drv_busy, e_busy);
        check_eq("smp_out", smp_out, e_smp);
        check_eq("smp_change", smp_change, e_chg);
        acc = cmd_valid && exp_rdy;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (left[c] > 1) begin
                    left[c]--;
                end else if (mq[c].size() > 0) begin
                    ent     = mq[c].pop_front();
                    cur[c]  = ent[11:4];
                    left[c] = int'(ent[3:0]) + 1;
                end else begin
                    left[c] = 0;
                end
            end
            if (acc) begin
                mq[cmd_chan].push_back({cmd_data, cmd_hold});
            end
            hist.push_back(smp_in);
            if (hist.size() > SKEW) begin
                void'(hist.pop_front());
            end
            nout = (hist.size() == SKEW) ? hist[0] : '0;
            for (int c = 0; c < CH; c++) begin
                e_chg[c] = (nout[c*8 +: 8] != e_smp[c*8 +: 8]);
            end
            e_smp = nout;
        end
        #1;
    endtask

    task automatic offer(input logic [CW-1:0] ch, input logic [7:0] d, input logic [3:0] h);
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_data  = d;
        cmd_hold  = h;
        run_cycle();
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            run_cycle();
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_chan  = '0;
        cmd_data  = '0;
        cmd_hold  = '0;
        smp_in    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        run_cycle();
        rst = 1'b0;

        // Idle after reset
        idle(5);
        check_eq("idle_ready0", cmd_ready, 1'b1);

        // Single command with hold 2, then idle with value retained
        offer(2'd0, 8'hA5, 4'd2);
        idle(6);
        check_eq("a5_kept", drv_out[7:0], 8'hA5);
        check_eq("a5_idle", drv_busy[0], 1'b0);

        // Back-to-back commands on channel 1
        offer(2'd1, 8'h11, 4'd0);
        offer(2'd1, 8'h22, 4'd0);
        offer(2'd1, 8'h33, 4'd1);
        offer(2'd1, 8'h44, 4'd0);
        idle(6);

        // Fill channel 0 with long holds; keep offering across a pop-while-full
        for (int i = 0; i < 5; i++) begin
            offer(2'd0, 8'(8'hC0 + i), 4'd15);
        end
        check_eq("full_reject", cmd_ready, 1'b0);
        cmd_chan = 2'd1;
        #1;
        check_eq("other_chan_ok", cmd_ready, 1'b1);
        for (int i = 0; i < 20; i++) begin
            offer(2'd0, 8'(8'hD0 + i), 4'd15);
        end
        idle(2);

        // Sample step on channel 1
        smp_in[15:8] = 8'h3C;
        run_cycle();
        check_eq("smp_step", smp_out[15:8], 8'h3C);
        check_eq("smp_pulse", smp_change[1], 1'b1);
        run_cycle();
        check_eq("smp_no_pulse", smp_change[1], 1'b0);
        idle(2);

        // Reset in the middle of a hold with commands queued
        offer(2'd2, 8'h77, 4'd7);
        offer(2'd2, 8'h66, 4'd1);
        offer(2'd2, 8'h55, 4'd1);
        idle(2);
        rst = 1'b1;
        run_cycle();
        check_eq("rst_drv", drv_out[23:16], RV);
        check_eq("rst_busy", drv_busy, 3'b000);
        rst = 1'b0;

        // Out-of-range channel is never accepted
        for (int i = 0; i < 3; i++) begin
            offer(2'd3, 8'hEE, 4'd0);
        end
        check_eq("bad_chan_ready", cmd_ready, 1'b0);
        idle(2);
        check_eq("bad_chan_drv", drv_out[23:16], RV);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) == 0);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_chan  = 2'($urandom_range(0, 3));
            cmd_data  = 8'($urandom);
            cmd_hold  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 2));
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    smp_in[c*8 +: 8] = 8'($urandom);
                end
            end
            run_cycle();
        end
        rst = 1'b0;
        idle(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
